// File: rtl/axi_read_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_master
// Purpose  : AXI4 read initiator. Turns one simple request (address, beat
//            count) into a single INCR burst on AR/R and streams the returned
//            beats to a consumer with backpressure. One transaction at a time.
// Ports    : ACLK/ARESETn         clock, async active-low reset
//            req_valid/req_ready  request handshake (req_addr, req_len)
//            data_*               beat stream towards the consumer
//            done/err             end-of-transaction pulse and its status
//            AR*/R*               AXI4 read address / read data channels
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_master #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [31:0] data_out,
  output logic        data_last,
  output logic        done,
  output logic        err,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state_q;
  logic        req_ready_q;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic [3:0]  arlen_q;
  logic [3:0]  len_q;
  logic [3:0]  beat_q;
  logic        err_acc_q;
  logic        done_q;
  logic        err_q;

  logic        in_data;
  logic        r_hs;
  logic        beat_err;
  logic        err_next;
  logic        unused_addr_lsbs;

  // Byte lane bits of the request address are discarded (word aligned bursts).
  assign unused_addr_lsbs = ^req_addr[1:0];

  assign in_data = (state_q == ST_DATA);
  // RREADY is a pure pass-through of the consumer's ready while in DATA.
  assign r_hs    = in_data && RVALID && data_ready;

  // A beat is bad on a slave error response, a foreign ID, or when RLAST
  // disagrees with the requested length (early or missing last beat).
  assign beat_err = (RRESP != 2'b00) ||
                    (RID != MASTER_ID) ||
                    (RLAST && (beat_q != len_q)) ||
                    (!RLAST && (beat_q == len_q));
  assign err_next = err_acc_q | beat_err;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      arvalid_q   <= 1'b0;
      araddr_q    <= 32'd0;
      arlen_q     <= 4'd0;
      len_q       <= 4'd0;
      beat_q      <= 4'd0;
      err_acc_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q     <= ST_ADDR;
            req_ready_q <= 1'b0;
            arvalid_q   <= 1'b1;
            araddr_q    <= {req_addr[31:2], 2'b00};
            arlen_q     <= req_len;
            len_q       <= req_len;
            err_acc_q   <= 1'b0;
          end
        end
        ST_ADDR: begin
          // AR fields are held in registers, so they stay stable until ARREADY.
          if (ARREADY) begin
            state_q   <= ST_DATA;
            arvalid_q <= 1'b0;
            araddr_q  <= 32'd0;
            arlen_q   <= 4'd0;
            beat_q    <= 4'd0;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            // Counter only checks the length; it wraps if RLAST never comes.
            beat_q    <= beat_q + 4'd1;
            err_acc_q <= err_next;
            if (RLAST) begin
              state_q     <= ST_IDLE;
              req_ready_q <= 1'b1;
              done_q      <= 1'b1;
              err_q       <= err_next;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign done       = done_q;
  assign err        = err_q;

  assign ARVALID    = arvalid_q;
  assign ARADDR     = araddr_q;
  assign ARLEN      = arlen_q;
  assign ARID       = arvalid_q ? MASTER_ID : 4'd0;
  assign ARSIZE     = arvalid_q ? 3'b010    : 3'b000;
  assign ARBURST    = arvalid_q ? 2'b01     : 2'b00;

  assign RREADY     = in_data && data_ready;
  assign data_valid = in_data && RVALID;
  assign data_out   = in_data ? RDATA : 32'd0;
  assign data_last  = in_data && RLAST;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_master
// Purpose  : Directed self-checking bench for axi_read_master with a small
//            configurable AXI read slave (ROM-like contents).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_read_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [3:0]  req_len = 4'd0;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic [31:0] data_out;
  logic        data_last;
  logic        done;
  logic        err;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi_read_master #(.MASTER_ID(4'd0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready),
    .data_out(data_out), .data_last(data_last),
    .done(done), .err(err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  // ---------------- slave model ----------------
  int          cfg_ar_delay  = 0;
  int          cfg_err_beat  = -1;
  int          cfg_last_beat = -1;
  bit          cfg_bad_rid   = 1'b0;
  logic        s_busy;
  int          s_beat;
  logic [31:0] s_base;
  logic [3:0]  s_len;
  int          ar_wait;

  function automatic logic [31:0] mem_word(input logic [31:0] widx);
    return widx * 32'h0001_0001 + 32'h5A00_0000;
  endfunction

  function automatic int last_idx(input int cfg, input logic [3:0] len);
    return (cfg < 0) ? int'(len) : cfg;
  endfunction

  assign ARREADY = ARVALID && !s_busy && (ar_wait >= cfg_ar_delay);
  assign RVALID  = s_busy;
  assign RDATA   = s_busy ? mem_word(s_base + s_beat) : 32'd0;
  assign RRESP   = (s_busy && s_beat == cfg_err_beat) ? 2'b10 : 2'b00;
  assign RID     = cfg_bad_rid ? 4'h5 : 4'h0;
  assign RLAST   = s_busy && (s_beat == last_idx(cfg_last_beat, s_len));

  // Synchronous slave reset so that outstanding beats remain visible
  // on the bus during an asynchronous master reset.
  always @(posedge ACLK) begin
    if (!ARESETn) begin
      s_busy <= 1'b0; s_beat <= 0; s_base <= 32'd0; s_len <= 4'd0; ar_wait <= 0;
    end else begin
      if (ARVALID && ARREADY) begin
        s_busy <= 1'b1; s_beat <= 0; s_base <= ARADDR >> 2; s_len <= ARLEN; ar_wait <= 0;
      end else if (ARVALID) ar_wait <= ar_wait + 1;
      else ar_wait <= 0;
      if (s_busy && RREADY) begin
        if (RLAST) s_busy <= 1'b0;
        else s_beat <= s_beat + 1;
      end
    end
  end

  // ---------------- transaction runner (collects, does not judge) ----------
  logic [31:0] rx_data[$];
  logic        rx_last[$];
  int          arv_cyc, ar_unstable, early_r, rr_bad;
  logic [44:0] ar_snap;

  task automatic run_txn(input logic [31:0] addr, input logic [3:0] len, input bit stall,
                         output int nbeats, output bit got_done, output logic got_err,
                         output int gap);
    int  stall_left;
    int  last_k;
    int  k;
    bit  hs;
    nbeats = 0; got_done = 0; got_err = 1'bx; gap = -1; stall_left = 0; last_k = -100;
    rx_data.delete(); rx_last.delete();
    arv_cyc = 0; ar_unstable = 0; early_r = 0; rr_bad = 0;
    data_ready = 1'b1;
    @(posedge ACLK); #1;
    req_valid = 1'b1; req_addr = addr; req_len = len;
    k = 0;
    while (k < 20) begin
      @(negedge ACLK);
      if (req_ready) break;
      k++;
    end
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge ACLK);
      if (ARVALID) begin
        arv_cyc++;
        if (arv_cyc == 1) ar_snap = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
        else if (ar_snap !== {ARID, ARADDR, ARLEN, ARSIZE, ARBURST}) ar_unstable++;
        if (RREADY) early_r++;
      end
      if (data_valid && (RREADY !== data_ready)) rr_bad++;
      if (done) begin
        got_done = 1; got_err = err; gap = k - last_k;
        break;
      end
      hs = data_valid && data_ready;
      if (hs) begin
        rx_data.push_back(data_out); rx_last.push_back(data_last);
        nbeats++; last_k = k;
        if (stall && (nbeats == 1 || nbeats == 2)) stall_left = 2;
      end
      @(posedge ACLK); #1;
      if (stall_left > 0) begin data_ready = 1'b0; stall_left--; end
      else data_ready = 1'b1;
    end
    data_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    data_ready = 1'b1;
    req_valid  = 1'b1;
    @(negedge ACLK);
    if ({req_ready, ARVALID, RREADY, data_valid, data_last, done, err} !== 7'b1000000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 1000000",
        {req_ready, ARVALID, RREADY, data_valid, data_last, done, err});
    end
    total++;
    if ({ARID, ARADDR, ARLEN, ARSIZE, ARBURST, data_out} !== 77'd0) begin
      bad++; $display("FAIL reset_fields: got %h want 0", {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, data_out});
    end
    total++;
    req_valid = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  task automatic test_single();
    data_ready = 1'b1;
    @(posedge ACLK); #1;
    req_valid = 1'b1; req_addr = 32'h0000_0104; req_len = 4'd0;
    @(negedge ACLK);
    if (req_ready !== 1'b1) begin bad++; $display("FAIL single_idle_ready: got %b want 1", req_ready); end
    total++;
    @(posedge ACLK); #1;                       // acceptance edge N
    req_valid = 1'b0;
    @(negedge ACLK);                           // cycle N+1
    if ({ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, req_ready} !==
        {1'b1, 4'd0, 32'h104, 4'd0, 3'd2, 2'd1, 1'b0}) begin
      bad++; $display("FAIL single_ar: got %h want %h",
        {ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, req_ready},
        {1'b1, 4'd0, 32'h104, 4'd0, 3'd2, 2'd1, 1'b0});
    end
    total++;
    @(negedge ACLK);                           // cycle N+2
    if ({data_valid, data_last, RREADY, ARVALID, data_out} !== {4'b1110, mem_word(32'h41)}) begin
      bad++; $display("FAIL single_beat: got %h want %h",
        {data_valid, data_last, RREADY, ARVALID, data_out}, {4'b1110, mem_word(32'h41)});
    end
    total++;
    @(negedge ACLK);                           // cycle N+3
    if ({done, err, req_ready} !== 3'b101) begin
      bad++; $display("FAIL single_done: got %b want 101", {done, err, req_ready});
    end
    total++;
    @(negedge ACLK);
    if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got %b want 0", done); end
    total++;
  endtask

  task automatic test_burst_stall();
    int n; bit d; logic e; int g;
    logic [3:0] lastv;
    int dbad;
    run_txn(32'h0000_0203, 4'd3, 1'b1, n, d, e, g);
    if (n !== 4) begin bad++; $display("FAIL burst_count: got %0d want 4", n); end
    total++;
    dbad = 0; lastv = 4'd0;
    for (int i = 0; i < n && i < 4; i++) begin
      if (rx_data[i] !== mem_word(32'h80 + i)) dbad++;
      lastv[i] = rx_last[i];
    end
    if (dbad !== 0) begin bad++; $display("FAIL burst_data: got %0d bad beats want 0", dbad); end
    total++;
    if (lastv !== 4'b1000) begin bad++; $display("FAIL burst_last: got %b want 1000", lastv); end
    total++;
    if ({d, e} !== 2'b10) begin bad++; $display("FAIL burst_done_err: got %b want 10", {d, e}); end
    total++;
    if (g !== 1) begin bad++; $display("FAIL burst_done_gap: got %0d want 1", g); end
    total++;
    if (rr_bad !== 0) begin bad++; $display("FAIL burst_rready_track: got %0d want 0", rr_bad); end
    total++;
  endtask

  task automatic test_ar_delay();
    int n; bit d; logic e; int g;
    cfg_ar_delay = 3;
    run_txn(32'h0000_1000, 4'd1, 1'b0, n, d, e, g);
    cfg_ar_delay = 0;
    if (arv_cyc !== 4) begin bad++; $display("FAIL ardly_cycles: got %0d want 4", arv_cyc); end
    total++;
    if ({ar_unstable, early_r} !== 64'd0) begin
      bad++; $display("FAIL ardly_stable: got unstable=%0d early=%0d want 0 0", ar_unstable, early_r);
    end
    total++;
    if ({n, d, e} !== {32'd2, 2'b10}) begin
      bad++; $display("FAIL ardly_txn: got n=%0d done=%b err=%b want 2 1 0", n, d, e);
    end
    total++;
  endtask

  task automatic test_errors();
    int n; bit d; logic e; int g;
    cfg_err_beat = 1;
    run_txn(32'h0000_0040, 4'd3, 1'b0, n, d, e, g);
    cfg_err_beat = -1;
    if ({n, d, e} !== {32'd4, 2'b11}) begin
      bad++; $display("FAIL err_rresp: got n=%0d done=%b err=%b want 4 1 1", n, d, e);
    end
    total++;
    cfg_bad_rid = 1'b1;
    run_txn(32'h0000_0050, 4'd0, 1'b0, n, d, e, g);
    cfg_bad_rid = 1'b0;
    if ({n, d, e} !== {32'd1, 2'b11}) begin
      bad++; $display("FAIL err_rid: got n=%0d done=%b err=%b want 1 1 1", n, d, e);
    end
    total++;
    cfg_last_beat = 1;
    run_txn(32'h0000_0060, 4'd3, 1'b0, n, d, e, g);
    if ({n, d, e, req_ready} !== {32'd2, 3'b111}) begin
      bad++; $display("FAIL err_early_last: got n=%0d done=%b err=%b rdy=%b want 2 1 1 1", n, d, e, req_ready);
    end
    total++;
    cfg_last_beat = 3;
    run_txn(32'h0000_0070, 4'd1, 1'b0, n, d, e, g);
    cfg_last_beat = -1;
    if ({n, d, e} !== {32'd4, 2'b11}) begin
      bad++; $display("FAIL err_missing_last: got n=%0d done=%b err=%b want 4 1 1", n, d, e);
    end
    total++;
    run_txn(32'h0000_0800, 4'd15, 1'b0, n, d, e, g);
    if ({n, d, e} !== {32'd16, 2'b10}) begin
      bad++; $display("FAIL len15: got n=%0d done=%b err=%b want 16 1 0", n, d, e);
    end
    total++;
    if (n == 16 && rx_data[15] !== mem_word(32'h20F)) begin
      bad++; $display("FAIL len15_data: got %h want %h", rx_data[15], mem_word(32'h20F));
    end
    total++;
  endtask

  task automatic test_reset_mid();
    int n; bit d; logic e; int g;
    int k;
    bit seen;
    data_ready = 1'b1;
    @(posedge ACLK); #1;
    req_valid = 1'b1; req_addr = 32'h0000_0900; req_len = 4'd7;
    k = 0;
    while (k < 20) begin @(negedge ACLK); if (req_ready) break; k++; end
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    seen = 0;
    for (k = 0; k < 20 && !seen; k++) begin
      @(negedge ACLK);
      if (data_valid && data_ready) seen = 1;
    end
    if (!seen) begin bad++; $display("FAIL rstmid_first_beat: got 0 want 1"); end
    total++;
    @(posedge ACLK); #1;                       // beat 1 taken at this edge
    ARESETn = 1'b0;
    #1;
    if ({req_ready, ARVALID, RREADY, data_valid, data_last, done, err} !== 7'b1000000) begin
      bad++; $display("FAIL rstmid_ctrl: got %b want 1000000",
        {req_ready, ARVALID, RREADY, data_valid, data_last, done, err});
    end
    total++;
    if ({ARID, ARADDR, ARLEN, ARSIZE, ARBURST, data_out} !== 77'd0) begin
      bad++; $display("FAIL rstmid_fields: got %h want 0", {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, data_out});
    end
    total++;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    run_txn(32'h0000_0A00, 4'd2, 1'b0, n, d, e, g);
    if ({n, d, e} !== {32'd3, 2'b10}) begin
      bad++; $display("FAIL rstmid_after: got n=%0d done=%b err=%b want 3 1 0", n, d, e);
    end
    total++;
    if (n == 3 && {rx_data[0], rx_data[2]} !== {mem_word(32'h280), mem_word(32'h282)}) begin
      bad++; $display("FAIL rstmid_after_data: got %h %h", rx_data[0], rx_data[2]);
    end
    total++;
  endtask

  task automatic test_back_to_back();
    int  n_done;
    bit  pend;
    int  k;
    int  dbad;
    logic [31:0] exp_w [5];
    logic        e2;
    exp_w[0] = mem_word(32'hC0);  exp_w[1] = mem_word(32'hC1);
    exp_w[2] = mem_word(32'h100); exp_w[3] = mem_word(32'h101); exp_w[4] = mem_word(32'h102);
    rx_data.delete();
    n_done = 0; pend = 0; e2 = 1'bx;
    data_ready = 1'b1;
    @(posedge ACLK); #1;
    req_valid = 1'b1; req_addr = 32'h0000_0300; req_len = 4'd1;
    k = 0;
    while (k < 20) begin @(negedge ACLK); if (req_ready) break; k++; end
    @(posedge ACLK); #1;
    req_addr = 32'h0000_0400; req_len = 4'd2;  // req_valid stays high
    for (k = 0; k < 60; k++) begin
      @(negedge ACLK);
      if (pend) begin
        if ({ARVALID, ARADDR, ARLEN} !== {1'b1, 32'h400, 4'd2}) begin
          bad++; $display("FAIL b2b_second_ar: got %h want %h", {ARVALID, ARADDR, ARLEN}, {1'b1, 32'h400, 4'd2});
        end
        total++;
        pend = 0;
      end
      if (data_valid && data_ready) rx_data.push_back(data_out);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept_in_done: got %b want 1", req_ready); end
          total++;
          pend = 1;
        end else begin
          e2 = err;
          break;
        end
      end
      @(posedge ACLK); #1;
      if (pend) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    if ({n_done, e2} !== {32'd2, 1'b0}) begin
      bad++; $display("FAIL b2b_done: got n_done=%0d err=%b want 2 0", n_done, e2);
    end
    total++;
    dbad = (rx_data.size() == 5) ? 0 : 100;
    for (int i = 0; i < 5 && i < rx_data.size(); i++) if (rx_data[i] !== exp_w[i]) dbad++;
    if (dbad !== 0) begin
      bad++; $display("FAIL b2b_beats: got %0d beats (%0d errors) want 5 (0)", rx_data.size(), dbad);
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_stall();
    test_ar_delay();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_read_master.md
# axi_read_master

AXI4 read initiator that turns a simple single-request interface into one INCR burst on the AR/R channels and streams the returned beats out with backpressure. It is the master-side counterpart to the memory wrappers (ROM, SRAM) on the read path, and is used by boot-copy and DMA-style engines to fetch words through the bus without owning AXI handshaking themselves. One transaction is in flight at a time.

## Interface
- MASTER_ID, 4'd0, value driven on ARID; also the expected RID.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_addr  in  32  byte address of the first word; bits [1:0] are ignored and driven as 0.
- req_len  in  4  number of beats minus 1 (0..15).
- data_valid  out  1  beat available on data_out.
- data_ready  in  1  consumer accepts the beat.
- data_out  out  32  beat data.
- data_last  out  1  final beat of the burst.
- done  out  1  one-cycle pulse at the end of the transaction.
- err  out  1  error status of the finished transaction; valid while done=1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  4/32/4/3/2/1  AXI read address channel.
- ARREADY  in  1  AXI read address channel ready.
- RID/RDATA/RRESP/RLAST/RVALID  in  4/32/2/1/1  AXI read data channel.
- RREADY  out  1  AXI read data channel ready.

## Operation
- FSM states: IDLE, ADDR, DATA. Reset state is IDLE.
- IDLE
  - req_ready=1.
  - On req_valid: latch req_addr (with [1:0] forced to 0) and req_len, clear the error accumulator, go to ADDR.
- ADDR
  - ARVALID=1 with ARID=MASTER_ID, ARADDR=addr_reg, ARLEN=len_reg, ARSIZE=3'b010, ARBURST=2'b01 (INCR).
  - All AR fields stay stable until ARREADY.
  - On ARVALID&&ARREADY: clear the beat counter (4 bits) and go to DATA.
- DATA
  - RREADY=data_ready, combinational pass-through.
  - data_valid=RVALID, data_out=RDATA, data_last=RLAST.
- On each R handshake (RVALID&&RREADY):
  - Increment the beat counter.
  - Set the error accumulator if any of these holds: RRESP!=2'b00; RID!=MASTER_ID; RLAST=1 with counter!=len_reg; counter==len_reg with RLAST=0.
- Burst end: the handshake with RLAST=1 returns the FSM to IDLE. Termination follows RLAST only; the counter is used only for checking.
- If RLAST is missing, the block keeps accepting beats until RLAST arrives. The counter wraps modulo 16, and the accumulator stays set.
- done and err are registered and assert the cycle after the last handshake. err holds the accumulator value and is 0 when done=0.
- Outside DATA: data_valid=0, data_last=0, data_out=0, RREADY=0.
- Outside ADDR: ARVALID=0 and all AR fields are 0.
- Bursts crossing a 4 KB boundary are not split or checked; the requester must avoid them.
- Reset, asynchronous at any point including mid-burst:
  - FSM returns to IDLE and the counter and registers clear.
  - Outputs take their reset values: req_ready=1, ARVALID=0, AR fields 0, RREADY=0, data_valid=0, data_last=0, data_out=0, done=0, err=0.
  - Beats still outstanding on the bus are not drained.

## Timing
- Request accepted at edge N (req_valid&&req_ready). ARVALID is high during cycle N+1.
- Zero-wait slave (ARREADY in the first ADDR cycle, RVALID the following cycle):
  - AR handshake at edge N+1.
  - First R beat in cycle N+2.
  - For single-beat bursts, done in cycle N+3, and req_ready is high again in N+3.
- Throughput is one beat per cycle when RVALID and data_ready are both held high.
- Back-to-back requests: the earliest next acceptance is the cycle done is high, so there is no overlap.
- req_valid in ADDR or DATA is ignored (req_ready=0); the requester holds it until accepted.
- RREADY has no register stage. data_ready-to-RREADY latency is 0 cycles.

## Test plan
- Single beat against a zero-wait ROM model: req_addr=0x0000_0104, req_len=0 -> ARADDR=0x104, ARLEN=0, ARSIZE=2, ARBURST=1; data_out=mem[0x41] with data_last=1; done at N+3 with err=0.
- 4-beat burst, data_ready low on beats 2 and 3 for 2 cycles each -> RREADY tracks data_ready, exactly 4 beats delivered in order, done one cycle after beat 4, err=0.
- ARREADY delayed 3 cycles -> ARVALID held for 4 cycles, AR fields constant throughout, no R beats accepted before the AR handshake.
- Error paths: RRESP=2'b10 on beat 2 of 4 -> all 4 beats delivered, err=1 with done. Wrong RID -> err=1. RLAST on beat 2 with req_len=3 -> FSM returns to IDLE after beat 2, done with err=1.
- ARESETn asserted mid-burst after beat 1 of 8 -> every output at its reset value immediately; a new request after release completes normally with err=0.
- Back-to-back: req_valid held high across two requests -> the second is accepted in the done cycle of the first, ARVALID rises the next cycle, and there are no dropped or duplicated beats.
